// File: rtl/loop_bank_ctrl.sv
// Bank controller for the looper: maps four front-panel buttons onto per-bank
// record/play/stop/delete state, quantises starts to the loop wrap and queues deletes.
module loop_bank_ctrl #(
  parameter int NBANKS      = 16,
  parameter int BANK_W      = 4,
  parameter int ADDR_W      = 22,
  parameter int HOLD_CYCLES = 150000000,
  parameter int CNT_W       = 28,
  parameter int QUANTIZE    = 1
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              btn_back,
  input  logic              btn_stop,
  input  logic              btn_play,
  input  logic              btn_next,
  input  logic [ADDR_W-1:0] current_address,
  input  logic              delete_clear,
  output logic [BANK_W-1:0] bank,
  output logic [NBANKS-1:0] playing,
  output logic [NBANKS-1:0] recording,
  output logic [NBANKS-1:0] active,
  output logic [NBANKS-1:0] pending,
  output logic              delete,
  output logic [BANK_W-1:0] delete_bank,
  output logic              set_max,
  output logic              reset_max
);

  localparam logic [CNT_W-1:0]  HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [BANK_W-1:0] LAST = BANK_W'(NBANKS - 1);

  logic              loop_set;
  logic [NBANKS-1:0] delete_pend;
  logic [NBANKS-1:0] pend_rec;
  logic [CNT_W-1:0]  hold_cnt;
  logic              prev_back, prev_stop, prev_play, prev_next;
  logic [ADDR_W-1:0] prev_addr;

  logic [BANK_W-1:0] n_bank, n_delete_bank, low_idx;
  logic [NBANKS-1:0] n_playing, n_recording, n_active, n_pending, n_pend_rec, n_delete_pend;
  logic [NBANKS-1:0] sel_oh, low_oh, del_req;
  logic [CNT_W-1:0]  n_hold;
  logic              n_delete, n_set_max, n_reset_max, n_loop_set;
  logic              wrap, stop_press, play_press, back_press, next_press;
  logic              rec_taken, sel_rec, sel_act, sel_play, any_rec, quant, start_rec;

  assign stop_press = btn_stop & ~prev_stop;
  assign play_press = btn_play & ~prev_play;
  assign back_press = btn_back & ~prev_back;
  assign next_press = btn_next & ~prev_next;
  assign wrap       = loop_set && (current_address == '0) && (prev_addr != '0);

  // Next-state: scheduler, then wrap, then the single serviced press against post-wrap state
  always_comb begin
    n_bank        = bank;
    n_playing     = playing;
    n_recording   = recording;
    n_active      = active;
    n_pending     = pending;
    n_pend_rec    = pend_rec;
    n_delete      = delete;
    n_delete_bank = delete_bank;
    n_delete_pend = delete_pend;
    n_loop_set    = loop_set;
    n_hold        = hold_cnt;
    n_set_max     = 1'b0;
    n_reset_max   = 1'b0;
    del_req       = '0;
    rec_taken     = 1'b0;
    start_rec     = 1'b0;
    sel_oh        = '0;
    low_oh        = '0;
    low_idx       = '0;

    for (int i = 0; i < NBANKS; i++) begin
      sel_oh[i] = (bank == BANK_W'(i));
    end
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (delete_pend[i]) begin
        low_idx   = BANK_W'(i);
        low_oh    = '0;
        low_oh[i] = 1'b1;
      end
    end

    if (delete) begin
      if (delete_clear) n_delete = 1'b0;
    end else if (delete_pend != '0) begin
      n_delete      = 1'b1;
      n_delete_bank = low_idx;
      n_delete_pend = delete_pend & ~low_oh;
    end

    // Only the lowest-index pending record start wins; a second recorder would break the one-hot rule
    if (wrap) begin
      rec_taken = |recording;
      for (int i = 0; i < NBANKS; i++) begin
        if (pending[i]) begin
          if (pend_rec[i]) begin
            if (!rec_taken) begin
              n_recording[i] = 1'b1;
              n_playing[i]   = 1'b0;
              rec_taken      = 1'b1;
            end
          end else begin
            n_playing[i] = 1'b1;
          end
        end
      end
      n_pending  = '0;
      n_pend_rec = '0;
    end

    sel_rec = |(n_recording & sel_oh);
    sel_act = |(n_active & sel_oh);
    sel_play = |(n_playing & sel_oh);
    any_rec = |n_recording;
    quant   = (QUANTIZE != 0) && loop_set;

    if (!btn_stop) begin
      n_hold = '0;
    end else if (!stop_press && hold_cnt != HOLD) begin
      n_hold = hold_cnt + CNT_W'(1);
      if (hold_cnt + CNT_W'(1) == HOLD) del_req = sel_oh;
    end

    if (stop_press) begin
      if (sel_rec) begin
        del_req = sel_oh;
        n_hold  = HOLD;
      end else begin
        n_playing  = n_playing & ~sel_oh;
        n_pending  = n_pending & ~sel_oh;
        n_pend_rec = n_pend_rec & ~sel_oh;
        n_hold     = CNT_W'(1);
        if (HOLD == CNT_W'(1)) del_req = sel_oh;
      end
    end else if (play_press) begin
      if (sel_rec) begin
        n_recording = n_recording & ~sel_oh;
        n_active    = n_active | sel_oh;
        n_playing   = n_playing | sel_oh;
        // First loop defines the length; anything not recorded against it is stale
        if (!loop_set) begin
          n_set_max     = 1'b1;
          n_loop_set    = 1'b1;
          n_delete_pend = n_delete_pend | (~active & ~sel_oh);
        end
      end else if (!any_rec) begin
        start_rec = !sel_act || sel_play;
        if (quant) begin
          n_pending  = n_pending | sel_oh;
          n_pend_rec = start_rec ? (n_pend_rec | sel_oh) : (n_pend_rec & ~sel_oh);
        end else if (start_rec) begin
          n_recording = n_recording | sel_oh;
          n_playing   = n_playing & ~sel_oh;
        end else begin
          n_playing = n_playing | sel_oh;
        end
      end
    end else if (back_press) begin
      if (!btn_stop && !any_rec) n_bank = (bank == '0) ? LAST : bank - BANK_W'(1);
    end else if (next_press) begin
      if (!btn_stop && !any_rec) n_bank = (bank == LAST) ? '0 : bank + BANK_W'(1);
    end

    if (del_req != '0) begin
      n_active      = n_active & ~del_req;
      n_playing     = n_playing & ~del_req;
      n_recording   = n_recording & ~del_req;
      n_pending     = n_pending & ~del_req;
      n_pend_rec    = n_pend_rec & ~del_req;
      n_delete_pend = n_delete_pend | del_req;
      if (n_active == '0 && n_recording == '0 && n_loop_set) begin
        n_reset_max = 1'b1;
        n_loop_set  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      bank        <= '0;
      playing     <= '0;
      recording   <= '0;
      active      <= '0;
      pending     <= '0;
      pend_rec    <= '0;
      delete      <= 1'b0;
      delete_bank <= '0;
      delete_pend <= '0;
      set_max     <= 1'b0;
      reset_max   <= 1'b1;
      loop_set    <= 1'b0;
      hold_cnt    <= '0;
      prev_back   <= 1'b0;
      prev_stop   <= 1'b0;
      prev_play   <= 1'b0;
      prev_next   <= 1'b0;
      prev_addr   <= '0;
    end else begin
      bank        <= n_bank;
      playing     <= n_playing;
      recording   <= n_recording;
      active      <= n_active;
      pending     <= n_pending;
      pend_rec    <= n_pend_rec;
      delete      <= n_delete;
      delete_bank <= n_delete_bank;
      delete_pend <= n_delete_pend;
      set_max     <= n_set_max;
      reset_max   <= n_reset_max;
      loop_set    <= n_loop_set;
      hold_cnt    <= n_hold;
      prev_back   <= btn_back;
      prev_stop   <= btn_stop;
      prev_play   <= btn_play;
      prev_next   <= btn_next;
      prev_addr   <= current_address;
    end
  end

endmodule

// File: tb/tb_loop_bank_ctrl.sv
// Directed bench for loop_bank_ctrl: a quantised instance is checked throughout,
// an unquantised twin driven by the same inputs is checked at the quantised start.
module tb_loop_bank_ctrl;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        btn_back = 1'b0, btn_stop = 1'b0, btn_play = 1'b0, btn_next = 1'b0;
  logic [21:0] current_address = '0;
  logic        delete_clear = 1'b0;

  logic [3:0]  bank, delete_bank, q0_bank, q0_delete_bank;
  logic [15:0] playing, recording, active, pending;
  logic [15:0] q0_playing, q0_recording, q0_active, q0_pending;
  logic        delete, set_max, reset_max, q0_delete, q0_set_max, q0_reset_max;

  int total = 0;
  int bad = 0;

  always #5 clk100 = ~clk100;

  loop_bank_ctrl #(.NBANKS(16), .BANK_W(4), .ADDR_W(22), .HOLD_CYCLES(100), .CNT_W(28), .QUANTIZE(1)) dut (
    .clk100(clk100), .rst(rst), .btn_back(btn_back), .btn_stop(btn_stop), .btn_play(btn_play),
    .btn_next(btn_next), .current_address(current_address), .delete_clear(delete_clear),
    .bank(bank), .playing(playing), .recording(recording), .active(active), .pending(pending),
    .delete(delete), .delete_bank(delete_bank), .set_max(set_max), .reset_max(reset_max));

  loop_bank_ctrl #(.NBANKS(16), .BANK_W(4), .ADDR_W(22), .HOLD_CYCLES(100), .CNT_W(28), .QUANTIZE(0)) dut_q0 (
    .clk100(clk100), .rst(rst), .btn_back(btn_back), .btn_stop(btn_stop), .btn_play(btn_play),
    .btn_next(btn_next), .current_address(current_address), .delete_clear(delete_clear),
    .bank(q0_bank), .playing(q0_playing), .recording(q0_recording), .active(q0_active),
    .pending(q0_pending), .delete(q0_delete), .delete_bank(q0_delete_bank),
    .set_max(q0_set_max), .reset_max(q0_reset_max));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  // 0=back 1=stop 2=play 3=next; one idle cycle first so the press is a fresh edge
  task automatic applyStimulus(input int which);
    step(1);
    case (which)
      0: btn_back = 1'b1;
      1: btn_stop = 1'b1;
      2: btn_play = 1'b1;
      default: btn_next = 1'b1;
    endcase
    step(1);
    btn_back = 1'b0;
    btn_stop = 1'b0;
    btn_play = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic holdStop(input int n);
    step(1);
    btn_stop = 1'b1;
    step(n);
    btn_stop = 1'b0;
  endtask

  task automatic doWrap();
    current_address = 22'd4000;
    step(1);
    current_address = 22'd0;
    step(1);
  endtask

  task automatic recordWrapped(input logic [15:0] bit_mask, input logic [15:0] active_after);
    applyStimulus(2);
    checkOutput("arm pending", pending, bit_mask);
    doWrap();
    checkOutput("wrap recording", recording, bit_mask);
    current_address = 22'd100;
    applyStimulus(2);
    checkOutput("wrapped finish active", active, active_after);
  endtask

  task automatic drainDeletes();
    for (int i = 0; i < 100; i++) begin
      delete_clear = delete;
      step(1);
    end
    delete_clear = 1'b0;
    checkOutput("drain idle", delete, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state
    step(2);
    checkOutput("rst bank", bank, 0);
    checkOutput("rst active", active, 0);
    checkOutput("rst delete", delete, 0);
    checkOutput("rst set_max", set_max, 0);
    checkOutput("rst reset_max", reset_max, 1);
    rst = 1'b0;
    step(1);
    checkOutput("reset_max drop", reset_max, 0);

    // first recording on bank 0 and the stale-bank delete chain
    applyStimulus(2);
    checkOutput("rec start", recording, 16'h0001);
    step(10);
    checkOutput("rec held", recording, 16'h0001);
    current_address = 22'd1000;
    applyStimulus(2);
    checkOutput("first stop rec", recording, 0);
    checkOutput("first active", active, 16'h0001);
    checkOutput("first playing", playing, 16'h0001);
    checkOutput("set_max pulse", set_max, 1);
    step(1);
    checkOutput("set_max drop", set_max, 0);
    for (int k = 1; k < 16; k++) begin
      checkOutput($sformatf("chain del %0d", k), delete, 1);
      checkOutput($sformatf("chain bank %0d", k), delete_bank, k);
      step(1);
      checkOutput($sformatf("chain hold %0d", k), delete, 1);
      delete_clear = 1'b1;
      step(1);
      delete_clear = 1'b0;
      checkOutput($sformatf("chain drop %0d", k), delete, 0);
      step(1);
    end
    checkOutput("chain done", delete, 0);

    // bank navigation wraps both ways
    applyStimulus(0);
    checkOutput("back from 0", bank, 15);
    applyStimulus(3);
    checkOutput("next from 15", bank, 0);
    applyStimulus(3);
    checkOutput("next to 1", bank, 1);

    // quantised start on an empty bank
    applyStimulus(3);
    checkOutput("goto 2", bank, 2);
    current_address = 22'd500;
    applyStimulus(2);
    checkOutput("q pending", pending, 16'h0004);
    checkOutput("q not rec", recording, 0);
    checkOutput("q0 immediate rec", q0_recording, 16'h0004);
    checkOutput("q0 no pending", q0_pending, 0);
    doWrap();
    checkOutput("wrap rec", recording, 16'h0004);
    checkOutput("wrap pending clr", pending, 0);
    checkOutput("wrap playing", playing, 16'h0001);
    current_address = 22'd100;
    applyStimulus(2);
    checkOutput("bank2 active", active, 16'h0005);
    checkOutput("bank2 playing", playing, 16'h0005);
    checkOutput("no set_max when set", set_max, 0);

    // hold-to-delete threshold on bank 2
    holdStop(99);
    checkOutput("stop clears play", playing, 16'h0001);
    checkOutput("hold99 active", active, 16'h0005);
    step(2);
    checkOutput("hold99 no delete", delete, 0);
    step(1);
    btn_stop = 1'b1;
    step(99);
    checkOutput("hold100 pre", active, 16'h0005);
    step(1);
    checkOutput("hold100 active", active, 16'h0001);
    step(1);
    checkOutput("hold del", delete, 1);
    checkOutput("hold del bank", delete_bank, 2);
    delete_clear = 1'b1;
    step(1);
    delete_clear = 1'b0;
    checkOutput("hold del drop", delete, 0);
    btn_next = 1'b1;
    step(1);
    btn_next = 1'b0;
    checkOutput("next ignored in hold", bank, 2);
    step(8);
    checkOutput("hold single delete", delete, 0);
    btn_stop = 1'b0;
    step(2);
    checkOutput("hold release", delete, 0);

    // deleting the last active bank clears the loop
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("goto 0", bank, 0);
    holdStop(100);
    checkOutput("clear-all active", active, 0);
    checkOutput("clear-all reset_max", reset_max, 1);
    step(1);
    checkOutput("reset_max one cycle", reset_max, 0);
    checkOutput("clear-all del", delete, 1);
    checkOutput("clear-all del bank", delete_bank, 0);
    delete_clear = 1'b1;
    step(1);
    delete_clear = 1'b0;
    applyStimulus(2);
    checkOutput("fresh rec immediate", recording, 16'h0001);
    checkOutput("fresh no pending", pending, 0);
    applyStimulus(2);
    checkOutput("fresh set_max", set_max, 1);
    step(1);
    checkOutput("chain again", delete, 1);

    // asynchronous reset aborts the in-flight delete
    rst = 1'b1;
    #2;
    checkOutput("async delete", delete, 0);
    checkOutput("async reset_max", reset_max, 1);
    checkOutput("async active", active, 0);
    step(2);
    rst = 1'b0;
    step(1);
    checkOutput("rst2 reset_max", reset_max, 0);

    // queued deletes: busy on bank 0, then 5 and 3 raised, serviced lowest first
    applyStimulus(2);
    applyStimulus(2);
    drainDeletes();
    checkOutput("base active", active, 16'h0001);
    repeat (3) applyStimulus(3);
    checkOutput("goto 3", bank, 3);
    recordWrapped(16'h0008, 16'h0009);
    repeat (2) applyStimulus(3);
    checkOutput("goto 5", bank, 5);
    recordWrapped(16'h0020, 16'h0029);
    repeat (5) applyStimulus(0);
    checkOutput("back to 0", bank, 0);
    holdStop(100);
    step(1);
    checkOutput("busy del", delete, 1);
    checkOutput("busy bank", delete_bank, 0);
    repeat (5) applyStimulus(3);
    holdStop(100);
    repeat (2) applyStimulus(0);
    holdStop(100);
    checkOutput("q active empty", active, 0);
    checkOutput("q reset_max", reset_max, 1);
    checkOutput("still busy", delete_bank, 0);
    delete_clear = 1'b1;
    step(1);
    delete_clear = 1'b0;
    checkOutput("busy drop", delete, 0);
    step(1);
    checkOutput("q first del", delete, 1);
    checkOutput("q first bank", delete_bank, 3);
    step(2);
    checkOutput("q first waits", delete_bank, 3);
    delete_clear = 1'b1;
    step(1);
    delete_clear = 1'b0;
    step(1);
    checkOutput("q second del", delete, 1);
    checkOutput("q second bank", delete_bank, 5);
    delete_clear = 1'b1;
    step(1);
    delete_clear = 1'b0;
    step(2);
    checkOutput("q idle", delete, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
